key_pad_emulator: RTL and testbench

Emulates a 4x4 membrane keypad at the pin level: it answers the row scan driven by the keypad scanner with column levels, as a physical key would. A host requests a key press with a 4-bit key code, and the block plays it out: contact bounce, hold, release bounce, then a mandatory gap. It sits across the row/column pins from the team's scanner, as an in-system test stimulus and for board-to-board keypad injection.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_pad_emulator.sv | 148 ++++++++++++++
 tb/tb_key_pad_emulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator FSM encoding, idle pin level and the
// key-code-to-matrix-position map used by both emulator and scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } kp_state_t;

  // Active-low lines rest at all ones.
  localparam logic [3:0] KP_IDLE_LVL = 4'hF;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Row in the upper two bits, column in the lower two.
  function automatic key_pos_t key_split(input logic [3:0] code);
    key_pos_t p;
    p.row = code[3:2];
    p.col = code[1:0];
    return p;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, resets to all ones so idle active-low lines stay idle.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_pad_emulator.sv
// Pin-level 4x4 keypad emulator: plays one requested key press (bounce in,
// hold, bounce out, gap) and answers the scanner's row drive on the columns.
module key_pad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2_000_000,
  parameter int BOUNCE_CYCLES  = 50_000,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int GAP_CYCLES     = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       pressed,
  input  logic [3:0] row_in,
  output logic [3:0] col_out
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES)
                      ? ((HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES)
                      : ((GAP_CYCLES > BOUNCE_CYCLES) ? GAP_CYCLES : BOUNCE_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = (BOUNCE_TOGGLES < 1) ? 1 : $clog2(BOUNCE_TOGGLES + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(BOUNCE_TOGGLES - 1);

  kp_state_t     state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;
  logic [3:0]    code_q;
  logic [3:0]    row_s2;
  logic [3:0]    col_nxt;
  key_pos_t      kp;

  sync_2ff #(.W(4)) u_row_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (row_in),
    .q    (row_s2)
  );

  // Press sequencer: one down-counter times every state and bounce phase;
  // pressed is registered so the contact level changes on phase boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= '0;
      pressed   <= 1'b0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      code_q    <= '0;
    end else begin
      case (state)
        IDLE: if (key_valid) begin
          code_q    <= key_code;
          busy      <= 1'b1;
          key_ready <= 1'b0;
          pressed   <= 1'b1;
          phase     <= '0;
          if (BOUNCE_TOGGLES == 0) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
          end else begin
            state <= BOUNCE_IN;
            cnt   <= BOUNCE_LD;
          end
        end
        BOUNCE_IN: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (phase == LAST_PH) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            phase   <= '0;
            pressed <= 1'b1;
          end else begin
            // next phase even -> closed, i.e. current phase odd
            phase   <= phase + 1'b1;
            cnt     <= BOUNCE_LD;
            pressed <= phase[0];
          end
        end
        HOLD: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            pressed <= 1'b0;
            phase   <= '0;
            if (BOUNCE_TOGGLES == 0) begin
              state <= GAP;
              cnt   <= GAP_LD;
            end else begin
              state <= BOUNCE_OUT;
              cnt   <= BOUNCE_LD;
            end
          end
        end
        BOUNCE_OUT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (phase == LAST_PH) begin
            state   <= GAP;
            cnt     <= GAP_LD;
            phase   <= '0;
            pressed <= 1'b0;
          end else begin
            // release pattern is inverted: odd phases closed
            phase   <= phase + 1'b1;
            cnt     <= BOUNCE_LD;
            pressed <= ~phase[0];
          end
        end
        GAP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state     <= IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pressed   <= 1'b0;
          busy      <= 1'b0;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

  // Only the latched row gates the latched column; other rows are ignored.
  always_comb begin
    kp      = key_split(code_q);
    col_nxt = KP_IDLE_LVL;
    if (pressed && !row_s2[kp.row]) col_nxt[kp.col] = 1'b0;
  end

  // Registered column return, no combinational path from pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_out <= KP_IDLE_LVL;
    else        col_out <= col_nxt;
  end

endmodule

// File: tb/tb_key_pad_emulator.sv
// Bench: two emulators (no bounce / four bounce phases) share all inputs and
// are compared every cycle against a timeline model of a key press.
module tb_key_pad_emulator;

  localparam int H = 20;
  localparam int B = 3;
  localparam int G = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic       kr0, bz0, pr0, kr1, bz1, pr1;
  logic [3:0] co0, co1;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 = no bounce, 1 = four bounce phases
  bit         m_busy [2];
  int         m_k    [2];
  logic [3:0] m_code [2];
  bit         m_pr   [2];
  logic [3:0] e_col  [2];
  logic [3:0] q1, q2;

  always #5 clk = ~clk;

  key_pad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(B), .BOUNCE_TOGGLES(0), .GAP_CYCLES(G)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(kr0), .busy(bz0), .pressed(pr0), .row_in(row_in), .col_out(co0));

  key_pad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(B), .BOUNCE_TOGGLES(4), .GAP_CYCLES(G)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(kr1), .busy(bz1), .pressed(pr1), .row_in(row_in), .col_out(co1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int tog(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic int total(input int t);
    return 2 * t * B + H + G;
  endfunction

  // contact level k cycles after the accepting edge
  function automatic bit press_at(input int t, input int k);
    if (k < t * B)         return ((k / B) % 2) == 0;
    if (k < t * B + H)     return 1'b1;
    if (k < 2 * t * B + H) return (((k - t * B - H) / B) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] col_fn(input bit p, input logic [3:0] code, input logic [3:0] rows);
    logic [3:0] c;
    c = 4'hF;
    if (p && rows[code[3:2]] == 1'b0) c[code[1:0]] = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_k[i] = 0; m_code[i] = 4'h0; m_pr[i] = 0;
    end
    q1 = 4'hF; q2 = 4'hF;
  endtask

  task automatic check_all();
    chk("ready0", kr0, !m_busy[0]);
    chk("busy0",  bz0, m_busy[0]);
    chk("press0", pr0, m_pr[0]);
    chk("col0",   co0, e_col[0]);
    chk("ready1", kr1, !m_busy[1]);
    chk("busy1",  bz1, m_busy[1]);
    chk("press1", pr1, m_pr[1]);
    chk("col1",   co1, e_col[1]);
  endtask

  // one clock: advance the model with the inputs seen at this edge, then check
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      e_col[i] = col_fn(m_pr[i], m_code[i], q2);
      if (m_busy[i]) begin
        m_k[i]++;
        if (m_k[i] == total(tog(i))) m_busy[i] = 0;
      end else if (key_valid) begin
        m_busy[i] = 1; m_k[i] = 0; m_code[i] = key_code;
      end
      m_pr[i] = m_busy[i] && press_at(tog(i), m_k[i]);
    end
    q2 = q1;
    q1 = row_in;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    chk("rst_col0", co0, 4'hF);
    chk("rst_rdy0", kr0, 1'b1);
    chk("rst_bsy0", bz0, 1'b0);
    chk("rst_col1", co1, 4'hF);
    chk("rst_rdy1", kr1, 1'b1);
    chk("rst_bsy1", bz1, 1'b0);
    chk("rst_pr1",  pr1, 1'b0);
    model_reset();
    for (int i = 0; i < 2; i++) e_col[i] = 4'hF;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] rows [5];
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011;
    rows[3] = 4'b0111; rows[4] = 4'b0000;
    model_reset();
    do_reset();
    repeat (3) step();

    // basic press, row 1 driven
    row_in = 4'b1101;
    press(4'h6);
    repeat (60) step();

    // row gating: sweep rows each cycle during the press
    press(4'h6);
    for (int n = 0; n < 60; n++) begin
      row_in = rows[n % 5];
      step();
    end

    // bounce pattern on column 3
    row_in = 4'b0111;
    press(4'hF);
    repeat (60) step();

    // request during HOLD is ignored
    row_in = 4'b0000;
    press(4'h9);
    repeat (14) step();
    key_code = 4'h0; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (60) step();

    // asynchronous reset in the middle of HOLD
    row_in = 4'b1101;
    press(4'h5);
    repeat (15) step();
    do_reset();
    repeat (5) step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) row_in = 4'($urandom);
      else                           row_in = rows[$urandom_range(0, 3)];
      key_code  = 4'($urandom);
      key_valid = ($urandom_range(0, 7) == 0);
      step();
    end
    key_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
